// File: rtl/ql_fifo_pkg.sv
// Shared definitions for the QuickLogic FIFO models: flag bit positions and a
// parameter legality check used at elaboration.
package ql_fifo_pkg;

  localparam int unsigned FF_EMPTY  = 0;
  localparam int unsigned FF_AEMPTY = 1;
  localparam int unsigned FF_AFULL  = 2;
  localparam int unsigned FF_FULL   = 3;

  function automatic bit thresholds_ok(int unsigned width, int unsigned addr_w,
                                       int unsigned upae, int unsigned upaf);
    int unsigned depth;
    if (width < 1 || width > 36) return 1'b0;
    if (addr_w < 2 || addr_w > 11) return 1'b0;
    depth = 1 << addr_w;
    if (upae < 1 || upae > depth - 2) return 1'b0;
    if (upaf < 1 || upaf > depth - 2) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ql_sync_fifo_if.sv
// FIFO request/response bundle; master drives requests, slave is the FIFO.
interface ql_sync_fifo_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              fflush;
  logic              wen;
  logic [WIDTH-1:0]  wdata;
  logic              ren;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic [3:0]        fflags;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output fflush, wen, wdata, ren,
    input  rdata, rvalid, fflags, count, overflow, underflow
  );

  modport slave (
    input  fflush, wen, wdata, ren,
    output rdata, rvalid, fflags, count, overflow, underflow
  );
endinterface

// File: rtl/ql_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module ql_fifo_mem #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the old word gives read-before-write on a shared address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ql_sync_fifo.sv
// Single-clock FIFO with programmable almost-empty/full thresholds, synchronous
// flush and sticky overflow/underflow flags.
module ql_sync_fifo import ql_fifo_pkg::*; #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned UPAE   = 4,
  parameter int unsigned UPAF   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ql_sync_fifo_if.slave  bus_io
);
  localparam int unsigned    Depth   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] AeLvl   = (ADDR_W + 1)'(UPAE);
  localparam logic [ADDR_W:0] AfLvl   = (ADDR_W + 1)'(Depth - UPAF);

  if (!thresholds_ok(WIDTH, ADDR_W, UPAE, UPAF)) begin : g_bad_param
    $error("ql_sync_fifo: illegal WIDTH/ADDR_W/UPAE/UPAF combination");
  end

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, rvalid_q, rvalid_d;
  logic              rd_acc, wr_acc;
  logic [3:0]        flags;

  always_comb begin
    rd_acc   = !bus_io.fflush && bus_io.ren && (count_q != '0);
    // On full a concurrent read frees a slot, so the write still goes through.
    wr_acc   = !bus_io.fflush && bus_io.wen && ((count_q != CntFull) || rd_acc);
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rvalid_d = rd_acc;
    if (bus_io.fflush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus_io.wen && !wr_acc) ovf_d = 1'b1;
      if (bus_io.ren && !rd_acc) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
    end
  end

  ql_fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (bus_io.fflush),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus_io.wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (bus_io.rdata)
  );

  always_comb begin
    flags            = '0;
    flags[FF_EMPTY]  = (count_q == '0);
    flags[FF_AEMPTY] = (count_q <= AeLvl);
    flags[FF_AFULL]  = (count_q >= AfLvl);
    flags[FF_FULL]   = (count_q == CntFull);
  end

  assign bus_io.fflags    = flags;
  assign bus_io.count     = count_q;
  assign bus_io.rvalid    = rvalid_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.underflow = unf_q;
endmodule

// File: tb/tb_ql_sync_fifo.sv
// Directed plus random bench for ql_sync_fifo (8-bit, depth 4, UPAE=UPAF=1)
// against a queue-based reference model.
module tb_ql_sync_fifo;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned UPAE  = 1;
  localparam int unsigned UPAF  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ql_sync_fifo_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  ql_sync_fifo #(
    .WIDTH  (W),
    .ADDR_W (AW),
    .UPAE   (UPAE),
    .UPAF   (UPAF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_rdata = '0;
  bit           m_rvalid = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    logic [3:0]  ef;
    n = mq.size();
    ef = {n == DEPTH, n >= DEPTH - UPAF, n <= UPAE, n == 0};
    chk({tag, ".count"},     32'(bus.count),     32'(n));
    chk({tag, ".fflags"},    32'(bus.fflags),    32'(ef));
    chk({tag, ".rvalid"},    32'(bus.rvalid),    32'(m_rvalid));
    chk({tag, ".rdata"},     32'(bus.rdata),     32'(m_rdata));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input bit fl, input bit w, input logic [W-1:0] wd,
                      input bit r);
    bit rd_ok, wr_ok;
    bus.fflush = fl;
    bus.wen    = w;
    bus.wdata  = wd;
    bus.ren    = r;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && (mq.size() < DEPTH || rd_ok);
      m_rvalid = rd_ok;
      if (rd_ok) m_rdata = mq.pop_front();
      if (wr_ok) mq.push_back(wd);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
    end
    check_all(tag);
  endtask

  initial begin
    bus.fflush = 1'b0;
    bus.wen    = 1'b0;
    bus.wdata  = '0;
    bus.ren    = 1'b0;
    model_reset();

    // Reset and idle
    #12;
    check_all("reset");
    #2 rst_n = 1'b1;
    step("idle", 0, 0, 8'h00, 0);

    // Fill, full read+write, overflow on full
    step("fill1", 0, 1, 8'h11, 0);
    step("fill2", 0, 1, 8'h22, 0);
    step("fill3", 0, 1, 8'h33, 0);
    step("fill4", 0, 1, 8'h44, 0);
    step("full_rw", 0, 1, 8'h55, 1);
    step("ovf", 0, 1, 8'h66, 0);

    // Drain past wrap, then underflow on empty
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 8'h00, 1);
    step("unf", 0, 0, 8'h00, 1);
    step("hold", 0, 0, 8'h00, 0);

    // Flush with three words and a concurrent write
    step("flush0", 0, 1, 8'hA1, 0);
    step("flush1", 0, 1, 8'hA2, 0);
    step("flush2", 0, 1, 8'hA3, 0);
    step("flush", 1, 1, 8'hA4, 1);
    step("post_flush", 0, 0, 8'h00, 1);
    step("post_flush_w", 0, 1, 8'hB0, 0);
    step("post_flush_r", 0, 0, 8'h00, 1);

    // Asynchronous reset mid-burst
    step("burst0", 0, 1, 8'hC1, 0);
    step("burst1", 0, 1, 8'hC2, 1);
    bus.wen = 1'b1;
    bus.wdata = 8'hC3;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    bus.wen = 1'b0;
    #3 rst_n = 1'b1;
    step("resume_w", 0, 1, 8'hD1, 0);
    step("resume_r", 0, 0, 8'h00, 1);

    // Random traffic, occasional flush
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           W'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
